escalonador_alarme_temperatura: RTL and testbench
=================================================

Name: escalonador_alarme_temperatura

Overview:
Sequencer that shares one threshold comparator among the plant's seven temperature sensors: core (SC), steam generators S1/S2/S3, return and supply pipes (TubSR/TubSS), and the 9-bit reactor sensor (Rea). It scans the sensors round-robin and filters each one with a persistence counter. Confirmed over-temperature events are latched until the operator acknowledges them. The block drives the audible temperature alarm of the control room.

Parameters:
SCAN_DIV, 4, clock cycles per channel evaluation (>=1)
PERSIST, 3, consecutive exceeding samples needed to latch a channel alarm (1..15)
LIM_SC, 40, core threshold (8-bit)
LIM_S, 100, threshold for S1, S2, S3, TubSR, TubSS (8-bit)
LIM_REA, 300, reactor threshold (9-bit)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sensTempSC  in  8  core temperature
sensTempS1  in  8  steam generator 1
sensTempS2  in  8  steam generator 2
sensTempS3  in  8  steam generator 3
sensTempTubSR  in  8  return pipe
sensTempTubSS  in  8  supply pipe
sensTempRea  in  9  reactor temperature
habilitar  in  1  scan enable; low freezes the scan
ackAlarme  in  1  operator acknowledge, one-cycle pulse
alarmeSonoroTemperatura  out  1  OR of all latched channel alarms (registered)
alarmesLatched  out  7  per-channel latched alarm, bit index = channel
canalAtual  out  3  channel under evaluation (0 SC, 1 S1, 2 S2, 3 S3, 4 TubSR, 5 TubSS, 6 Rea)
varreduraCompleta  out  1  one-cycle pulse on the cycle after channel 6 is evaluated

Behaviour:
- Reset (rst_n low, asynchronous): divCnt=0, canalAtual=0, all persistence counters=0, alarmesLatched=0, alarmeSonoroTemperatura=0, varreduraCompleta=0.
- Divider: divCnt counts 0..SCAN_DIV-1 while habilitar=1. tick = habilitar && divCnt==SCAN_DIV-1. On tick, divCnt returns to 0.
- habilitar=0: divCnt, canalAtual and counters hold. Latched alarms hold. ackAlarme is still honoured.
- Shared comparator: combinational mux selects the sensor at canalAtual. 8-bit channels are zero-extended to 9 bits. excede = value >= threshold of that channel. Equality counts as exceeding.
- On tick, for channel c = canalAtual:
  - excede=1: cnt[c] <= min(cnt[c]+1, PERSIST). If cnt[c]+1 >= PERSIST, alarmesLatched[c] <= 1.
  - excede=0: cnt[c] <= 0. The latched bit is unchanged.
  - canalAtual <= (c==6) ? 0 : c+1.
  - varreduraCompleta <= (c==6). Otherwise the pulse is 0 the next cycle.
- Persistence: cnt saturates at PERSIST. A single non-exceeding sample clears it. With PERSIST=1, one sample latches the alarm.
- Acknowledge: on ackAlarme=1, every bit c with cnt[c]==0 is cleared (the channel is currently below threshold). Bits with cnt[c]!=0 stay set.
- Simultaneous ack and set on the same channel in the same cycle: set wins, so the bit stays 1.
- alarmeSonoroTemperatura = registered OR of the next-state alarmesLatched. It rises on the clock edge that latches a bit, with zero added latency relative to alarmesLatched.
- Sensor inputs are sampled only on the tick cycle of their channel. Changes between evaluations are ignored.
- Worst-case detection latency for a channel: 7*SCAN_DIV*PERSIST cycles.
- Reset asserted mid-scan aborts the scan. After release, the scan restarts at channel 0 with a full SCAN_DIV wait.

Test Plan:
- Reset/idle: SCAN_DIV=4, PERSIST=3, all sensors 0, habilitar=1 for 100 cycles -> alarms stay 0. canalAtual steps 0..6 every 4 cycles. varreduraCompleta pulses every 28 cycles.
- Threshold boundary: sensTempSC=39 for 3 scans -> no alarm. Then sensTempSC=40 for 3 scans -> alarmesLatched[0]=1 and alarme=1 at the third channel-0 tick. Repeat with sensTempRea 299 vs 300 -> only bit 6 is set.
- Persistence reset: sensTempS2=150 for 2 scans, 90 for 1 scan, 150 for 2 scans -> no latch. A third consecutive exceeding scan -> bit 2 set.
- Acknowledge: latch bit 4 via TubSR=120, then pulse ackAlarme while still 120 -> bit stays set. Drop to 50, wait one scan, ack -> bit 4=0 and alarme=0.
- Ack/set collision: time ackAlarme to the exact tick on which TubSS reaches its PERSIST-th exceeding sample -> bit 5 ends at 1.
- Enable and async reset: drop habilitar mid-scan -> canalAtual and divCnt frozen for 20 cycles, and resume at the same point. Assert rst_n low asynchronously between clock edges with alarms latched -> all outputs 0 immediately, and the scan restarts at channel 0.

Source files
------------

// File: rtl/escalonador_alarme_temperatura.sv
// Round-robin temperature alarm sequencer: one shared threshold comparator,
// per-channel persistence filtering and operator-acknowledged alarm latches.

module escalonador_alarme_canal #(
    parameter int PERSIST = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic amostrar,
    input  logic excede,
    input  logic ack,
    output logic alarme_latched,
    output logic alarme_prox
);
    logic [3:0] cnt;
    logic [4:0] cnt_inc;
    logic       set_alarme;

    always_comb begin
        cnt_inc    = {1'b0, cnt} + 5'd1;
        set_alarme = amostrar && excede && (cnt_inc >= 5'(PERSIST));
        // ack only clears channels currently below threshold; a same-cycle set wins
        alarme_prox = set_alarme || (alarme_latched && !(ack && cnt == 4'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= 4'd0;
            alarme_latched <= 1'b0;
        end else begin
            if (amostrar) begin
                if (!excede)
                    cnt <= 4'd0;
                else if (cnt_inc >= 5'(PERSIST))
                    cnt <= 4'(PERSIST);
                else
                    cnt <= cnt_inc[3:0];
            end
            alarme_latched <= alarme_prox;
        end
    end
endmodule

module escalonador_alarme_temperatura #(
    parameter int SCAN_DIV = 4,
    parameter int PERSIST  = 3,
    parameter int LIM_SC   = 40,
    parameter int LIM_S    = 100,
    parameter int LIM_REA  = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sensTempSC,
    input  logic [7:0] sensTempS1,
    input  logic [7:0] sensTempS2,
    input  logic [7:0] sensTempS3,
    input  logic [7:0] sensTempTubSR,
    input  logic [7:0] sensTempTubSS,
    input  logic [8:0] sensTempRea,
    input  logic       habilitar,
    input  logic       ackAlarme,
    output logic       alarmeSonoroTemperatura,
    output logic [6:0] alarmesLatched,
    output logic [2:0] canalAtual,
    output logic       varreduraCompleta
);
    localparam int NUM_CANAIS = 7;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]         div_cnt;
    logic                  tick;
    logic [8:0]            valor;
    logic [8:0]            limite;
    logic                  excede;
    logic [NUM_CANAIS-1:0] amostrar;
    logic [NUM_CANAIS-1:0] latched_prox;

    assign tick = habilitar && (div_cnt == DW'(SCAN_DIV - 1));

    // Shared comparator; 8-bit sensors are zero-extended to the 9-bit reactor width
    always_comb begin
        valor  = sensTempRea;
        limite = 9'(LIM_REA);
        case (canalAtual)
            3'd0: begin valor = {1'b0, sensTempSC};    limite = 9'(LIM_SC); end
            3'd1: begin valor = {1'b0, sensTempS1};    limite = 9'(LIM_S);  end
            3'd2: begin valor = {1'b0, sensTempS2};    limite = 9'(LIM_S);  end
            3'd3: begin valor = {1'b0, sensTempS3};    limite = 9'(LIM_S);  end
            3'd4: begin valor = {1'b0, sensTempTubSR}; limite = 9'(LIM_S);  end
            3'd5: begin valor = {1'b0, sensTempTubSS}; limite = 9'(LIM_S);  end
            default: ;
        endcase
        excede = (valor >= limite);
    end

    for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
        assign amostrar[i] = tick && (canalAtual == 3'(i));
        escalonador_alarme_canal #(.PERSIST(PERSIST)) u_canal (
            .clk            (clk),
            .rst_n          (rst_n),
            .amostrar       (amostrar[i]),
            .excede         (excede),
            .ack            (ackAlarme),
            .alarme_latched (alarmesLatched[i]),
            .alarme_prox    (latched_prox[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt                 <= '0;
            canalAtual              <= 3'd0;
            varreduraCompleta       <= 1'b0;
            alarmeSonoroTemperatura <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt    <= '0;
                canalAtual <= (canalAtual == 3'd6) ? 3'd0 : canalAtual + 3'd1;
            end else if (habilitar) begin
                div_cnt <= div_cnt + DW'(1);
            end
            varreduraCompleta       <= tick && (canalAtual == 3'd6);
            alarmeSonoroTemperatura <= |latched_prox;
        end
    end
endmodule

// File: tb/tb_escalonador_alarme_temperatura.sv
// Directed bench for the temperature alarm sequencer (SCAN_DIV=4, PERSIST=3).

module tb_escalonador_alarme_temperatura;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sensTempSC = 8'd0, sensTempS1 = 8'd0, sensTempS2 = 8'd0, sensTempS3 = 8'd0;
    logic [7:0] sensTempTubSR = 8'd0, sensTempTubSS = 8'd0;
    logic [8:0] sensTempRea = 9'd0;
    logic       habilitar = 1'b1;
    logic       ackAlarme = 1'b0;
    logic       alarmeSonoroTemperatura;
    logic [6:0] alarmesLatched;
    logic [2:0] canalAtual;
    logic       varreduraCompleta;

    int checks = 0;
    int fails  = 0;

    escalonador_alarme_temperatura #(
        .SCAN_DIV(4), .PERSIST(3), .LIM_SC(40), .LIM_S(100), .LIM_REA(300)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .sensTempSC              (sensTempSC),
        .sensTempS1              (sensTempS1),
        .sensTempS2              (sensTempS2),
        .sensTempS3              (sensTempS3),
        .sensTempTubSR           (sensTempTubSR),
        .sensTempTubSS           (sensTempTubSS),
        .sensTempRea             (sensTempRea),
        .habilitar               (habilitar),
        .ackAlarme               (ackAlarme),
        .alarmeSonoroTemperatura (alarmeSonoroTemperatura),
        .alarmesLatched          (alarmesLatched),
        .canalAtual              (canalAtual),
        .varreduraCompleta       (varreduraCompleta)
    );

    always #5 clk = ~clk;

    // Returns on the negedge right after channel c has been evaluated (div back at 0).
    task automatic eval_done(input int c);
        int n = 0;
        while (canalAtual == 3'(c) && n < 200) begin @(negedge clk); n++; end
        while (canalAtual != 3'(c) && n < 200) begin @(negedge clk); n++; end
        while (canalAtual == 3'(c) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; fails++;
            $display("FAIL eval_timeout ch%0d: canal=%0d never advanced", c, canalAtual);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ackAlarme = 1'b1;
        @(negedge clk);
        ackAlarme = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({alarmesLatched, alarmeSonoroTemperatura, canalAtual, varreduraCompleta} !== 12'd0) begin
            fails++;
            $display("FAIL reset_state: got lat=%b alm=%b can=%0d vc=%b, want all 0",
                     alarmesLatched, alarmeSonoroTemperatura, canalAtual, varreduraCompleta);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            checks++;
            if (canalAtual !== 3'((k / 4) % 7) || varreduraCompleta !== (k % 28 == 0)
                || alarmesLatched !== 7'd0 || alarmeSonoroTemperatura !== 1'b0) begin
                fails++;
                $display("FAIL idle_k%0d: can=%0d vc=%b lat=%b alm=%b, want can=%0d vc=%b lat=0 alm=0",
                         k, canalAtual, varreduraCompleta, alarmesLatched, alarmeSonoroTemperatura,
                         (k / 4) % 7, (k % 28 == 0));
            end
        end
    endtask

    task automatic test_threshold();
        sensTempSC = 8'd39;
        repeat (3) eval_done(0);
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL sc_39: lat=%b want 0000000", alarmesLatched);
        end
        sensTempSC = 8'd40;
        repeat (2) eval_done(0);
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL sc_40_two: lat=%b want 0000000", alarmesLatched);
        end
        eval_done(0);
        checks++;
        if (alarmesLatched !== 7'b0000001 || alarmeSonoroTemperatura !== 1'b1) begin
            fails++; $display("FAIL sc_40_third: lat=%b alm=%b want 0000001/1", alarmesLatched, alarmeSonoroTemperatura);
        end
        sensTempSC = 8'd0;
        eval_done(0);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'd0 || alarmeSonoroTemperatura !== 1'b0) begin
            fails++; $display("FAIL sc_clear: lat=%b alm=%b want 0/0", alarmesLatched, alarmeSonoroTemperatura);
        end
        sensTempRea = 9'd299;
        repeat (3) eval_done(6);
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL rea_299: lat=%b want 0000000", alarmesLatched);
        end
        sensTempRea = 9'd300;
        repeat (3) eval_done(6);
        checks++;
        if (alarmesLatched !== 7'b1000000 || alarmeSonoroTemperatura !== 1'b1) begin
            fails++; $display("FAIL rea_300: lat=%b alm=%b want 1000000/1", alarmesLatched, alarmeSonoroTemperatura);
        end
        sensTempRea = 9'd0;
        eval_done(6);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL rea_clear: lat=%b want 0000000", alarmesLatched);
        end
    endtask

    task automatic test_persistence();
        sensTempS2 = 8'd150;
        repeat (2) eval_done(2);
        sensTempS2 = 8'd90;
        eval_done(2);
        sensTempS2 = 8'd150;
        repeat (2) eval_done(2);
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL persist_broken: lat=%b want 0000000", alarmesLatched);
        end
        eval_done(2);
        checks++;
        if (alarmesLatched !== 7'b0000100) begin
            fails++; $display("FAIL persist_third: lat=%b want 0000100", alarmesLatched);
        end
        sensTempS2 = 8'd0;
        eval_done(2);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL persist_clear: lat=%b want 0000000", alarmesLatched);
        end
    endtask

    task automatic test_ack();
        sensTempTubSR = 8'd120;
        repeat (3) eval_done(4);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'b0010000 || alarmeSonoroTemperatura !== 1'b1) begin
            fails++; $display("FAIL ack_while_hot: lat=%b alm=%b want 0010000/1", alarmesLatched, alarmeSonoroTemperatura);
        end
        sensTempTubSR = 8'd50;
        eval_done(4);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'd0 || alarmeSonoroTemperatura !== 1'b0) begin
            fails++; $display("FAIL ack_cooled: lat=%b alm=%b want 0000000/0", alarmesLatched, alarmeSonoroTemperatura);
        end
    endtask

    task automatic test_ack_collision();
        sensTempTubSS = 8'd200;
        repeat (2) eval_done(5);
        eval_done(4);                // canal=5, divider at 0
        repeat (3) @(negedge clk);   // divider at 3: next edge is channel 5's tick
        ackAlarme = 1'b1;
        @(negedge clk);
        ackAlarme = 1'b0;
        checks++;
        if (canalAtual !== 3'd6 || alarmesLatched !== 7'b0100000) begin
            fails++; $display("FAIL ack_collision: can=%0d lat=%b want 6/0100000", canalAtual, alarmesLatched);
        end
        sensTempTubSS = 8'd0;
        eval_done(5);
        pulse_ack();
        checks++;
        if (alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL collision_clear: lat=%b want 0000000", alarmesLatched);
        end
    endtask

    task automatic test_enable();
        eval_done(2);                // canal=3, divider at 0
        @(negedge clk);              // divider at 1
        habilitar = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (canalAtual !== 3'd3 || varreduraCompleta !== 1'b0) begin
                fails++; $display("FAIL frozen_k%0d: can=%0d vc=%b want 3/0", k, canalAtual, varreduraCompleta);
            end
        end
        habilitar = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (canalAtual !== 3'd3) begin
            fails++; $display("FAIL resume_hold: can=%0d want 3", canalAtual);
        end
        @(negedge clk);
        checks++;
        if (canalAtual !== 3'd4) begin
            fails++; $display("FAIL resume_step: can=%0d want 4", canalAtual);
        end
    endtask

    task automatic test_async_reset();
        sensTempSC = 8'd50;
        repeat (3) eval_done(0);
        checks++;
        if (alarmesLatched !== 7'b0000001 || alarmeSonoroTemperatura !== 1'b1) begin
            fails++; $display("FAIL pre_reset_latch: lat=%b alm=%b want 0000001/1", alarmesLatched, alarmeSonoroTemperatura);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({alarmesLatched, alarmeSonoroTemperatura, canalAtual, varreduraCompleta} !== 12'd0) begin
            fails++;
            $display("FAIL async_reset: lat=%b alm=%b can=%0d vc=%b want all 0",
                     alarmesLatched, alarmeSonoroTemperatura, canalAtual, varreduraCompleta);
        end
        sensTempSC = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (canalAtual !== 3'd0) begin
            fails++; $display("FAIL restart_hold: can=%0d want 0", canalAtual);
        end
        @(negedge clk);
        checks++;
        if (canalAtual !== 3'd1 || alarmesLatched !== 7'd0) begin
            fails++; $display("FAIL restart_step: can=%0d lat=%b want 1/0000000", canalAtual, alarmesLatched);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_threshold();
        test_persistence();
        test_ack();
        test_ack_collision();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
